// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// Decodes ALU control, runs the ALU, computes the branch target and
// latches everything into the EX/MEM pipeline register.
// Optional operand forwarding from EX/MEM and MEM/WB is enabled by
// defining the macro EX_FORWARD_EN; without it the forwarding ports
// are present but ignored.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       wb_in,
  input  logic [2:0]       mem_in,
  input  logic [3:0]       ex_in,
  input  logic [WIDTH-1:0] npc_in,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  input  logic [WIDTH-1:0] imm,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [1:0]       wb_out,
  output logic [2:0]       mem_out,
  output logic [WIDTH-1:0] branch_target,
  output logic             zero,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] store_data,
  output logic [4:0]       dst_reg,
  output logic             bad_funct
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_BAD
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  logic             regdst;
  logic [1:0]       aluop;
  logic             alusrc;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] op_b;
  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_next;
  logic [WIDTH-1:0] target_next;

  assign regdst = ex_in[3];
  assign aluop  = ex_in[2:1];
  assign alusrc = ex_in[0];
  assign funct  = imm[5:0];

`ifdef EX_FORWARD_EN
  // Operand forwarding: EX/MEM wins over MEM/WB; register 0 never forwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    op_a  = rdata1;
    fwd_b = rdata2;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs)
      op_a = exmem_result;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs)
      op_a = memwb_result;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rt)
      fwd_b = exmem_result;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rt)
      fwd_b = memwb_result;
  end
`else
  assign op_a  = rdata1;
  assign fwd_b = rdata2;

  // Forwarding ports and rs are intentionally ignored in this build.
  logic unused_fwd;
  assign unused_fwd = ^{rs, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result};
`endif

  assign op_b = alusrc ? imm : fwd_b;

  // ALU control decode from aluop and funct.
  always_comb begin
    alu_op = ALU_ADD;
    unique case (aluop)
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      2'b11: alu_op = ALU_ADD;
      2'b10: begin
        unique case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          default:   alu_op = ALU_BAD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  // ALU datapath; an unsupported funct yields zero.
  always_comb begin
    alu_next = '0;
    unique case (alu_op)
      ALU_ADD: alu_next = op_a + op_b;
      ALU_SUB: alu_next = op_a - op_b;
      ALU_AND: alu_next = op_a & op_b;
      ALU_OR:  alu_next = op_a | op_b;
      ALU_SLT: alu_next = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_BAD: alu_next = '0;
      default: alu_next = '0;
    endcase
  end

  assign target_next = npc_in + {imm[WIDTH-3:0], 2'b00};

  // EX/MEM pipeline register: rst > flush > stall > load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wb_out        <= '0;
      mem_out       <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      alu_result    <= '0;
      store_data    <= '0;
      dst_reg       <= '0;
      bad_funct     <= 1'b0;
    end else if (flush) begin
      // Bubble: control cleared, datapath loads but is meaningless.
      wb_out        <= '0;
      mem_out       <= '0;
      bad_funct     <= 1'b0;
      branch_target <= target_next;
      zero          <= (alu_next == '0);
      alu_result    <= alu_next;
      store_data    <= fwd_b;
      dst_reg       <= regdst ? rd : rt;
    end else if (!stall) begin
      wb_out        <= wb_in;
      mem_out       <= mem_in;
      bad_funct     <= (alu_op == ALU_BAD);
      branch_target <= target_next;
      zero          <= (alu_next == '0);
      alu_result    <= alu_next;
      store_data    <= fwd_b;
      dst_reg       <= regdst ? rd : rt;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage.
// Directed cases from the stage's behaviour list, then randomized
// stimulus compared against a behavioural model of the stage.
module tb_ex_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             flush;
  logic [1:0]       wb_in;
  logic [2:0]       mem_in;
  logic [3:0]       ex_in;
  logic [WIDTH-1:0] npc_in;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic [WIDTH-1:0] imm;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic             exmem_regwrite;
  logic [4:0]       exmem_rd;
  logic [WIDTH-1:0] exmem_result;
  logic             memwb_regwrite;
  logic [4:0]       memwb_rd;
  logic [WIDTH-1:0] memwb_result;
  logic [1:0]       wb_out;
  logic [2:0]       mem_out;
  logic [WIDTH-1:0] branch_target;
  logic             zero;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] store_data;
  logic [4:0]       dst_reg;
  logic             bad_funct;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] bt;
    logic        z;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic        bad;
  } exp_t;

  exp_t exp_q;
  bit   dp_known;

  ex_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wb_in(wb_in), .mem_in(mem_in), .ex_in(ex_in), .npc_in(npc_in),
    .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
    .rs(rs), .rt(rt), .rd(rd),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .wb_out(wb_out), .mem_out(mem_out), .branch_target(branch_target),
    .zero(zero), .alu_result(alu_result), .store_data(store_data),
    .dst_reg(dst_reg), .bad_funct(bad_funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Behavioural model of one loaded instruction, from the current inputs.
  function automatic exp_t model();
    exp_t        e;
    logic [31:0] a;
    logic [31:0] breg;
    logic [31:0] b;
    a    = rdata1;
    breg = rdata2;
`ifdef EX_FORWARD_EN
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) a = exmem_result;
    else if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) a = memwb_result;
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rt) breg = exmem_result;
    else if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rt) breg = memwb_result;
`endif
    b     = ex_in[0] ? imm : breg;
    e.wb  = wb_in;
    e.mem = mem_in;
    e.bad = 1'b0;
    e.alu = 32'h0;
    if (ex_in[2:1] == 2'b01) e.alu = a - b;
    else if (ex_in[2:1] != 2'b10) e.alu = a + b;
    else begin
      case (int'(imm[5:0]))
        32:      e.alu = a + b;
        34:      e.alu = a - b;
        36:      e.alu = a & b;
        37:      e.alu = a | b;
        42:      e.alu = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        default: e.bad = 1'b1;
      endcase
    end
    e.z   = (e.alu == 0);
    e.bt  = npc_in + imm * 32'd4;
    e.sd  = breg;
    e.dst = ex_in[3] ? rd : rt;
    return e;
  endfunction

  // Advance one clock with the current inputs, update the model, compare.
  task automatic step();
    exp_t n;
    n = model();
    if (rst) begin
      exp_q    = '{2'b0, 3'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0};
      dp_known = 1'b1;
    end else if (flush) begin
      exp_q.wb  = 2'b0;
      exp_q.mem = 3'b0;
      exp_q.bad = 1'b0;
      dp_known  = 1'b0;
    end else if (!stall) begin
      exp_q    = n;
      dp_known = 1'b1;
    end
    @(posedge clk);
    #1;
    check("wb_out", 32'(wb_out), 32'(exp_q.wb));
    check("mem_out", 32'(mem_out), 32'(exp_q.mem));
    check("bad_funct", 32'(bad_funct), 32'(exp_q.bad));
    if (dp_known) begin
      check("alu_result", alu_result, exp_q.alu);
      check("zero", 32'(zero), 32'(exp_q.z));
      check("branch_target", branch_target, exp_q.bt);
      check("store_data", store_data, exp_q.sd);
      check("dst_reg", 32'(dst_reg), 32'(exp_q.dst));
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0;
    wb_in = 0; mem_in = 0; ex_in = 0; npc_in = 0;
    rdata1 = 0; rdata2 = 0; imm = 0; rs = 0; rt = 0; rd = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic randomize_inputs();
    logic [5:0] functs [6];
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    wb_in  = 2'($urandom);
    mem_in = 3'($urandom);
    ex_in  = 4'($urandom);
    npc_in = $urandom;
    rdata1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
    rdata2 = ($urandom_range(0, 3) == 0) ? rdata1 : $urandom;
    imm    = $urandom;
    if ($urandom_range(0, 3) != 0) imm[5:0] = functs[$urandom_range(0, 5)];
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom);
    exmem_regwrite = 1'($urandom);
    exmem_rd       = 5'($urandom_range(0, 7));
    exmem_result   = $urandom;
    memwb_regwrite = 1'($urandom);
    memwb_rd       = 5'($urandom_range(0, 7));
    memwb_result   = $urandom;
  endtask

  initial begin
    logic [31:0] held_alu;
    logic [31:0] held_bt;
    logic [1:0]  held_wb;

    idle();
    dp_known = 1'b0;
    exp_q    = '{2'b0, 3'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0};

    // Reset with arbitrary inputs.
    randomize_inputs();
    rst = 1;
    step();
    check("reset_alu", alu_result, 32'h0);
    check("reset_wb", 32'(wb_out), 32'h0);
    check("reset_dst", 32'(dst_reg), 32'h0);

    // R-type sub.
    idle();
    ex_in = 4'b1100; imm = 32'b100010; rdata1 = 10; rdata2 = 10; rd = 7; wb_in = 2'b10;
    step();
    check("sub_alu", alu_result, 32'h0);
    check("sub_zero", 32'(zero), 32'h1);
    check("sub_dst", 32'(dst_reg), 32'd7);
    check("sub_wb", 32'(wb_out), 32'h2);

    // LW.
    idle();
    ex_in = 4'b0001; wb_in = 2'b11; mem_in = 3'b010; rdata1 = 32'h100;
    imm = 32'hFFFFFFFC; rt = 3;
    step();
    check("lw_alu", alu_result, 32'hFC);
    check("lw_dst", 32'(dst_reg), 32'd3);
    check("lw_mem", 32'(mem_out), 32'h2);

    // BEQ.
    idle();
    ex_in = 4'b0010; mem_in = 3'b100; npc_in = 32'h40; imm = 4; rdata1 = 5; rdata2 = 5;
    step();
    check("beq_target", branch_target, 32'h50);
    check("beq_zero", 32'(zero), 32'h1);
    check("beq_mem", 32'(mem_out), 32'h4);

    // SLT signed, then unsupported funct.
    idle();
    ex_in = 4'b0100; imm = 32'b101010; rdata1 = 32'hFFFFFFFF; rdata2 = 1;
    step();
    check("slt_alu", alu_result, 32'h1);
    imm = 32'h0;
    step();
    check("bad_alu", alu_result, 32'h0);
    check("bad_flag", 32'(bad_funct), 32'h1);
    check("bad_zero", 32'(zero), 32'h1);

    // Load something nonzero, then stall three cycles with changing inputs.
    idle();
    ex_in = 4'b0000; wb_in = 2'b11; mem_in = 3'b001; rdata1 = 32'h1234; rdata2 = 32'h11;
    npc_in = 32'h80; imm = 32'h10;
    step();
    held_alu = alu_result;
    held_bt  = branch_target;
    held_wb  = wb_out;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1;
      step();
      check("stall_alu", alu_result, held_alu);
      check("stall_bt", branch_target, held_bt);
      check("stall_wb", 32'(wb_out), 32'(held_wb));
    end

    // Flush wins over stall.
    randomize_inputs();
    wb_in = 2'b11; mem_in = 3'b111;
    stall = 1; flush = 1;
    step();
    check("flush_wb", 32'(wb_out), 32'h0);
    check("flush_mem", 32'(mem_out), 32'h0);

    // Forwarding priority: EX/MEM over MEM/WB.
    idle();
    rs = 4; rdata1 = 77;
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 9;
    memwb_regwrite = 1; memwb_rd = 4; memwb_result = 2;
    step();
`ifdef EX_FORWARD_EN
    check("fwd_a", alu_result, 32'd9);
`else
    check("nofwd_a", alu_result, 32'd77);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the registered `wb`/`mem`/`ex` control fields from decode, along with the ID/EX operands. It performs ALU control decode, the ALU operation, and branch-target computation, then latches the results into the EX/MEM pipeline register. Optional operand forwarding from EX/MEM and MEM/WB removes RAW stalls.

## Interface
- `WIDTH`, default 32: datapath width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high; clock clk.
- `stall`  in  1  hold the EX/MEM register contents.
- `flush`  in  1  insert bubble: zero the control fields on the next edge.
- `wb_in`  in  2  {regwrite, memtoreg}.
- `mem_in`  in  3  {branch, memread, memwrite}.
- `ex_in`  in  4  {regdst, aluop[1:0], alusrc}.
- `npc_in`  in  WIDTH  PC+4 of the instruction.
- `rdata1`, `rdata2`  in  WIDTH  register-file operands A and B.
- `imm`  in  WIDTH  sign-extended immediate; funct is `imm[5:0]`.
- `rs`, `rt`, `rd`  in  5  instruction register fields.
- `exmem_regwrite`  in  1, `exmem_rd`  in  5, `exmem_result`  in  WIDTH: EX/MEM forwarding source.
- `memwb_regwrite`  in  1, `memwb_rd`  in  5, `memwb_result`  in  WIDTH: MEM/WB forwarding source.
- `wb_out`  out  2, `mem_out`  out  3: registered control.
- `branch_target`  out  WIDTH  registered npc_in + (imm << 2).
- `zero`  out  1  registered (ALU result == 0).
- `alu_result`  out  WIDTH  registered ALU output.
- `store_data`  out  WIDTH  registered operand B, taken before the alusrc mux and after forwarding.
- `dst_reg`  out  5  registered `regdst ? rd : rt`.
- `bad_funct`  out  1  registered; set when an R-type instruction has an unsupported funct.

## Operation
- Operand A is `rdata1` after forwarding.
- Operand B is `imm` when `alusrc` is set; otherwise it is `rdata2` after forwarding.
- ALU control:
  - aluop 00 → add.
  - aluop 01 → subtract.
  - aluop 11 → add.
  - aluop 10 → decode funct:
    - 100000 → add.
    - 100010 → sub.
    - 100100 → and.
    - 100101 → or.
    - 101010 → slt (signed compare, result 0 or 1).
    - Any other funct → result 0 and `bad_funct`=1.
- Arithmetic is modulo 2^WIDTH. Overflow is ignored and no trap is raised.
- `branch_target` = npc_in + {imm[WIDTH-3:0], 2'b00}, with wrap-around permitted.
- `zero` is computed from the final ALU result, including the bad_funct case, where zero=1.
- Branch resolution is not done here. The MEM stage ANDs `mem_out[2]` with `zero`.

## Timing
- Latency is one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Priority per edge: rst > flush > stall > load.
- Reset value of all outputs: 0.
- flush:
  - `wb_out`, `mem_out` and `bad_funct` are set to 0.
  - Datapath outputs still load, so their values are don't-care.
- stall with no flush: every output holds its value.
- flush and stall asserted together: the flush takes effect.
- A reset asserted mid-stream clears everything on that edge. The inputs present on that edge are discarded.
- The forwarding mux is purely combinational in the same cycle and adds no latency.

## Configuration
- Macro: `EX_FORWARD_EN`.
- Defined, per operand (rs for A, rt for B):
  - If `exmem_regwrite` is set, `exmem_rd`≠0 and `exmem_rd` matches the operand's register, select `exmem_result`.
  - Otherwise, if the same conditions hold for `memwb_regwrite`/`memwb_rd`, select `memwb_result`.
  - Otherwise, select the register-file operand.
  - EX/MEM has priority over MEM/WB.
- Undefined:
  - Operands come directly from `rdata1`/`rdata2`.
  - Forwarding ports remain present but are ignored.
  - Hazards are resolved upstream by stalls.

## Test plan
- **Reset:** rst=1 with arbitrary inputs → all outputs 0 after the edge.
- **R-type sub:** ex_in=1100, funct=100010, rdata1=10, rdata2=10, rd=7 → alu_result=0, zero=1, dst_reg=7, wb_out=10.
- **LW:**
  - Stimulus: ex_in=0001, wb_in=11, mem_in=010, rdata1=0x100, imm=0xFFFFFFFC, rt=3.
  - Required: alu_result=0xFC, dst_reg=3, mem_out=010.
- **BEQ:** ex_in=0010, npc_in=0x40, imm=4, rdata1=5, rdata2=5 → branch_target=0x50, zero=1, mem_out=100.
- **SLT and bad funct:**
  - funct=101010, A=0xFFFFFFFF, B=1 → alu_result=1.
  - funct=000000 → alu_result=0, bad_funct=1.
- **Stall/flush and forwarding:**
  - stall=1 for 3 cycles → outputs hold.
  - flush=1 together with stall=1 → wb_out=00, mem_out=000.
  - With `EX_FORWARD_EN`, rs=4, exmem_rd=4 with result 9, memwb_rd=4 with result 2 → operand A=9.
